// File: rtl/multiplexing_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multiplexing_pkg: shared slot/state types and helpers for the         |
// | time-multiplexed column (input replay buffer and output demux).       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package multiplexing_pkg;

   typedef enum logic [0:0] {
      SLOT_A = 1'b0,
      SLOT_B = 1'b1
   } slot_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } demux_state_t;

   function automatic int half_len(input int g);
      return g / 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spike_time_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spike_time_capture: latches the first-spike offset of each neuron     |
// | within one half-slot; clear and a new capture may share a cycle.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module spike_time_capture #(
   parameter int Q  = 2,
   parameter int H  = 9,
   parameter int TW = $clog2(H)
) (
   input  logic                 clk,
   input  logic                 rstb,
   input  logic                 enable,
   input  logic                 clear,
   input  logic [TW-1:0]        offset,
   input  logic [Q-1:0]         spikes,
   output logic [Q-1:0]         valid,
   output logic [Q-1:0][TW-1:0] spike_time
);

   logic [Q-1:0]         valid_q, valid_d;
   logic [Q-1:0][TW-1:0] time_q, time_d;

   always_comb begin
      valid_d = clear ? '0 : valid_q;
      time_d  = clear ? '0 : time_q;
      // Spike at the boundary cycle belongs to the new frame, so it lands after the clear.
      if (enable) begin
         for (int q = 0; q < Q; q++) begin
            if (spikes[q] && !valid_d[q]) begin
               valid_d[q] = 1'b1;
               time_d[q]  = offset;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         valid_q <= '0;
         time_q  <= '0;
      end else begin
         valid_q <= valid_d;
         time_q  <= time_d;
      end
   end

   assign valid      = valid_q;
   assign spike_time = time_q;

endmodule
`default_nettype wire

// File: rtl/multiplexed_column_demux.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | multiplexed_column_demux: captures per-half-slot first spikes of the  |
// | shared column and replays them per network at full gamma time scale.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module multiplexed_column_demux
   import multiplexing_pkg::*;
#(
   parameter int Q                  = 2,
   parameter int GAMMA_CYCLE_LENGTH = 18
) (
   input  logic         clk,
   input  logic         rstb,
   input  logic         grst,
   input  logic [Q-1:0] col_spikes,
   output logic [Q-1:0] output_spikes1,
   output logic [Q-1:0] output_spikes2,
   output logic         slot,
   output logic         frame_valid
);

   localparam int G  = GAMMA_CYCLE_LENGTH;
   localparam int H  = half_len(G);
   localparam int CW = $clog2(G);
   localparam int TW = $clog2(H);

   demux_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          grst_q;
   logic          fv_q, fv_d;
   logic [1:0][Q-1:0]         rep_valid_q;
   logic [1:0][Q-1:0][TW-1:0] rep_time_q;

   logic          w_edge, w_run, w_boundary;
   slot_t         w_slot;
   logic [TW-1:0] w_off;
   logic [1:0][Q-1:0]         w_cap_valid, w_rep_valid, w_hit;
   logic [1:0][Q-1:0][TW-1:0] w_cap_time, w_rep_time;
   logic [CW-1:0] w_thr;

   always_comb begin
      w_edge  = grst & ~grst_q;
      // The first edge cycle already behaves as RUN: it is the empty first boundary.
      w_run   = (state_q == RUN) | w_edge;
      state_d = w_edge ? RUN : state_q;

      if (!w_run || w_edge || cnt_q == CW'(G - 1)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end

      w_boundary = w_run && (cnt_d == '0);
      w_slot     = (cnt_d >= CW'(H)) ? SLOT_B : SLOT_A;
      w_off      = (w_slot == SLOT_B) ? TW'(cnt_d - CW'(H)) : TW'(cnt_d);
      fv_d       = fv_q | (w_boundary && state_q == RUN);
   end

   spike_time_capture #(.Q(Q), .H(H), .TW(TW)) u_cap_a (
      .clk        (clk),
      .rstb       (rstb),
      .enable     (w_run && w_slot == SLOT_A),
      .clear      (w_boundary),
      .offset     (w_off),
      .spikes     (col_spikes),
      .valid      (w_cap_valid[0]),
      .spike_time (w_cap_time[0])
   );

   spike_time_capture #(.Q(Q), .H(H), .TW(TW)) u_cap_b (
      .clk        (clk),
      .rstb       (rstb),
      .enable     (w_run && w_slot == SLOT_B),
      .clear      (w_boundary),
      .offset     (w_off),
      .spikes     (col_spikes),
      .valid      (w_cap_valid[1]),
      .spike_time (w_cap_time[1])
   );

   // Replay sees the freshly committed frame already in the boundary cycle itself.
   always_comb begin
      w_rep_valid = w_boundary ? w_cap_valid : rep_valid_q;
      w_rep_time  = w_boundary ? w_cap_time  : rep_time_q;
      w_hit       = '0;
      w_thr       = '0;
      for (int n = 0; n < 2; n++) begin
         for (int q = 0; q < Q; q++) begin
            w_thr       = CW'(w_rep_time[n][q]) << 1;
            w_hit[n][q] = w_run && w_rep_valid[n][q] && (cnt_d >= w_thr);
         end
      end
   end

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         grst_q      <= 1'b0;
         fv_q        <= 1'b0;
         rep_valid_q <= '0;
         rep_time_q  <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         grst_q      <= grst;
         fv_q        <= fv_d;
         rep_valid_q <= w_rep_valid;
         rep_time_q  <= w_rep_time;
      end
   end

   assign output_spikes1 = w_hit[0];
   assign output_spikes2 = w_hit[1];
   assign slot           = w_slot;
   assign frame_valid    = fv_d;

endmodule
`default_nettype wire

// File: doc/multiplexed_column_demux.md
# multiplexed_column_demux

Output-side demultiplexer for the time-multiplexed column. The shared column evaluates network 1 in the first half of each gamma cycle and network 2 in the second half. This block captures the first-spike time of every column neuron in each half-slot. During the following gamma cycle it replays those spikes on two separate per-network output buses, restored to full gamma time scale (offset × 2). It sits directly after the column and drives `output_spikes1` / `output_spikes2` of the multiplexed column top.

## Interface
- `Q`, 2, column neurons per network
- `GAMMA_CYCLE_LENGTH`, 18, clk cycles per gamma cycle (G); must be even and ≥ 4; half-slot H = G/2
- `clk`  in  1  system clock
- `rstb`  in  1  reset; asynchronous, active-low
- `grst`  in  1  gamma square wave, period G clk; a rising edge marks gamma-cycle start
- `col_spikes`  in  Q  column output spikes, time-multiplexed (slot A = network 1, slot B = network 2)
- `output_spikes1`  out  Q  network 1 replayed spikes (step-coded)
- `output_spikes2`  out  Q  network 2 replayed spikes (step-coded)
- `slot`  out  1  current slot: 0 = A (cnt < H), 1 = B
- `frame_valid`  out  1  high while replaying a committed frame

## Operation
- States: IDLE (after reset, no gamma edge seen yet) and RUN.
- Gamma-edge detect: `grst` is sampled each clk. An edge cycle is one where the sample is 1 and the previous sample was 0. The first edge cycle moves IDLE→RUN.
- Counter cnt (width clog2(G)):
  - cnt = 0 in every edge cycle.
  - Otherwise cnt = previous cnt + 1, wrapping G-1→0.
  - An early edge resynchronises cnt to 0.
  - A missing edge lets cnt free-run and wrap.
- Capture, RUN only:
  - Slot A covers cnt 0..H-1; slot B covers cnt H..G-1.
  - Slot offset t = cnt (slot A) or cnt−H (slot B), range 0..H-1.
  - For each q, the first cycle in the slot with `col_spikes[q]`=1 sets cap_valid[slot][q] and cap_time[slot][q]=t.
  - Later spikes in the same slot are ignored.
- Commit, at every gamma boundary (cnt = 0 cycle, via wrap or edge):
  - Capture registers are copied to replay registers, then cleared.
  - A spike captured in the last cycle before the boundary is included in the commit.
  - On the first boundary after IDLE→RUN, the capture registers are empty; that frame commits all-zero and `frame_valid` stays 0 for it.
- Replay:
  - In the gamma cycle after commit, `output_spikesN[q]` = 1 in every cycle with rep_valid[N][q]=1 and cnt ≥ 2·rep_time[N][q]; otherwise 0.
  - Outputs are therefore monotonic within a gamma cycle and fall to 0 at the next boundary unless re-committed.
- `frame_valid` = 1 from the first commit of captured data onward while in RUN.
- Arithmetic: 2·t ≤ G−2, always in range; the compare uses clog2(G) bits unsigned.

## Timing
- Reset (rstb=0): all outputs 0; state IDLE; cnt, capture and replay registers cleared. Reset mid-frame discards all captured and replayed data.
- Latency:
  - A network-1 spike at slot offset t in gamma cycle k appears at cnt = 2t of gamma cycle k+1.
  - A network-2 spike at offset t appears at cnt = 2t of cycle k+1.
- `slot` is combinational from cnt and valid in the same cycle.
- In IDLE, `col_spikes` is ignored and all outputs are 0.
- An edge arriving in the same cycle as a natural wrap is a single boundary, with one commit.

## Structure
- Shared package `multiplexing_pkg` holds:
  - the `slot_t` enum (SLOT_A, SLOT_B) and the `demux_state_t` enum (IDLE, RUN);
  - a `half_len(G)` function;
  - these are reused by the input-side replay buffer.
- Sub-module `spike_time_capture`, parameterised by Q and H, instantiated once per slot:
  - inputs: enable, offset, spikes, clear;
  - outputs: valid[Q], time[Q].
- The top holds the edge detect, counter, state, replay registers and output compare.

## Test plan
- Reset held, grst toggling, `col_spikes`=2'b11 → all outputs 0, `frame_valid`=0; after release and before the first grst edge, outputs stay 0.
- G=18: `col_spikes[0]` pulses at cnt 3 of gamma k → `output_spikes1[0]` rises at cnt 6 of k+1 and stays high through cnt 17; `output_spikes2`=0.
- `col_spikes[1]` high from cnt 9 to 17 → `output_spikes2[1]` high for cnt 0..17 of k+1 (t=0); the first spike only is kept.
- Spike at cnt 17 of gamma k → `output_spikes2` rises at cnt 16 of k+1; no spikes in k+1 → all outputs 0 in k+2.
- grst edge arrives 5 clk early (cnt 12) → cnt resyncs to 0; the partial frame commits once; there is no double commit.
- rstb asserted at cnt 7 with spikes captured → outputs 0 immediately; no replay occurs after release until a new frame is captured.
